// File: rtl/barrel_shifter_if.sv
// Operand/result bundle for barrel_shifter; the rot signal exists only when
// BARREL_SHIFTER_ROTATE_EN is defined.
interface barrel_shifter_if #(
  parameter int unsigned WIDTH = 4
);
  localparam int unsigned SEL_W = $clog2(WIDTH);

  logic [WIDTH-1:0] in;
  logic [SEL_W-1:0] sel;
  logic             sft_lft;
  logic             in_valid;
`ifdef BARREL_SHIFTER_ROTATE_EN
  logic             rot;
`endif
  logic [WIDTH-1:0] out;
  logic             out_valid;

  modport master (
`ifdef BARREL_SHIFTER_ROTATE_EN
    output rot,
`endif
    output in, sel, sft_lft, in_valid,
    input  out, out_valid
  );

  modport slave (
`ifdef BARREL_SHIFTER_ROTATE_EN
    input  rot,
`endif
    input  in, sel, sft_lft, in_valid,
    output out, out_valid
  );
endinterface

// File: rtl/barrel_shifter.sv
// Logical barrel shifter: log-stage shift network into one output register.
// Define BARREL_SHIFTER_ROTATE_EN to add the rot input (rotate instead of zero-fill).
module barrel_shifter #(
  parameter int unsigned WIDTH = 4
) (
  input logic              clk,
  input logic              rst_n,
  barrel_shifter_if.slave  bus
);
  localparam int unsigned SEL_W = $clog2(WIDTH);

  logic [WIDTH-1:0] stage_d;
  logic [WIDTH-1:0] shifted;
`ifdef BARREL_SHIFTER_ROTATE_EN
  logic [WIDTH-1:0] wrapped;
`endif
  logic [WIDTH-1:0] out_q;
  logic             valid_q;

  // Stage k moves by 2^k; in rotate mode the bits pushed off one end are OR-ed back in at the other.
  always_comb begin
    stage_d = bus.in;
    shifted = '0;
`ifdef BARREL_SHIFTER_ROTATE_EN
    wrapped = '0;
`endif
    for (int unsigned k = 0; k < SEL_W; k++) begin
      if (bus.sel[k]) begin
        if (bus.sft_lft) begin
          shifted = stage_d << (32'd1 << k);
`ifdef BARREL_SHIFTER_ROTATE_EN
          wrapped = stage_d >> (WIDTH - (32'd1 << k));
`endif
        end else begin
          shifted = stage_d >> (32'd1 << k);
`ifdef BARREL_SHIFTER_ROTATE_EN
          wrapped = stage_d << (WIDTH - (32'd1 << k));
`endif
        end
`ifdef BARREL_SHIFTER_ROTATE_EN
        stage_d = bus.rot ? (shifted | wrapped) : shifted;
`else
        stage_d = shifted;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        out_q <= stage_d;
      end
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_barrel_shifter.sv
// Scoreboard bench for barrel_shifter at WIDTH=4 and WIDTH=8.
module tb_barrel_shifter;
  logic clk;
  logic rst_n;

  barrel_shifter_if #(.WIDTH(4)) b4 ();
  barrel_shifter_if #(.WIDTH(8)) b8 ();

  barrel_shifter #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
  barrel_shifter #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));

  logic [3:0] exp4_q[$];
  logic [7:0] exp8_q[$];

  int mon_total = 0;
  int mon_bad   = 0;
  int dir_total = 0;
  int dir_bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    logic [3:0] e4;
    logic [7:0] e8;
    if (b4.out_valid) begin
      mon_total++;
      if (exp4_q.size() == 0) begin
        mon_bad++;
        $display("FAIL w4_unexpected: out=%b with no expected result", b4.out);
      end else begin
        e4 = exp4_q.pop_front();
        if (b4.out !== e4) begin
          mon_bad++;
          $display("FAIL w4_out: got=%b want=%b", b4.out, e4);
        end
      end
    end
    if (b8.out_valid) begin
      mon_total++;
      if (exp8_q.size() == 0) begin
        mon_bad++;
        $display("FAIL w8_unexpected: out=%b with no expected result", b8.out);
      end else begin
        e8 = exp8_q.pop_front();
        if (b8.out !== e8) begin
          mon_bad++;
          $display("FAIL w8_out: got=%b want=%b", b8.out, e8);
        end
      end
    end
  end

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    dir_total++;
    if (got !== want) begin
      dir_bad++;
      $display("FAIL %s: got=%b want=%b", name, got, want);
    end
  endtask

  task automatic idle4();
    b4.in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  // Drives one valid 4-bit vector; the caller supplies the hand-computed result.
  task automatic issue4(input logic [3:0] a, input logic [1:0] s, input logic lft,
                        input logic r, input logic [3:0] want);
    b4.in = a; b4.sel = s; b4.sft_lft = lft; b4.in_valid = 1'b1;
`ifdef BARREL_SHIFTER_ROTATE_EN
    b4.rot = r;
`endif
    exp4_q.push_back(want);
    @(posedge clk); #1;
  endtask

  function automatic logic [7:0] model8(input logic [7:0] a, input int unsigned s,
                                        input logic lft, input logic r);
    logic [7:0] res;
    res = lft ? 8'(a << s) : (a >> s);
    if (r) res = res | (lft ? (a >> (8 - s)) : 8'(a << (8 - s)));
    return res;
  endfunction

  function automatic logic [3:0] model4(input logic [3:0] a, input int unsigned s,
                                        input logic lft, input logic r);
    logic [3:0] res;
    res = lft ? 4'(a << s) : (a >> s);
    if (r) res = res | (lft ? (a >> (4 - s)) : 4'(a << (4 - s)));
    return res;
  endfunction

  initial begin
    logic r;
    rst_n = 1'b1;
    b4.in = '0; b4.sel = '0; b4.sft_lft = 1'b0; b4.in_valid = 1'b0;
    b8.in = '0; b8.sel = '0; b8.sft_lft = 1'b0; b8.in_valid = 1'b0;
`ifdef BARREL_SHIFTER_ROTATE_EN
    b4.rot = 1'b0; b8.rot = 1'b0;
`endif
    #1 rst_n = 1'b0;
    #1;
    check("por_out4", 8'(b4.out), 8'h00);
    check("por_valid4", 8'(b4.out_valid), 8'h00);
    check("por_out8", b8.out, 8'h00);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Load 1010, then assert reset mid-cycle and expect an immediate clear.
    issue4(4'b1101, 2'b01, 1'b1, 1'b0, 4'b1010);
    idle4();
    check("pre_rst_out", 8'(b4.out), 8'b1010);
    rst_n = 1'b0;
    #1;
    check("async_rst_out", 8'(b4.out), 8'h00);
    check("async_rst_valid", 8'(b4.out_valid), 8'h00);
    #2 rst_n = 1'b1;
    repeat (3) idle4();
    check("post_rst_out", 8'(b4.out), 8'h00);
    check("post_rst_valid", 8'(b4.out_valid), 8'h00);

    issue4(4'b1101, 2'b00, 1'b1, 1'b0, 4'b1101);
    issue4(4'b1101, 2'b01, 1'b1, 1'b0, 4'b1010);
    issue4(4'b1101, 2'b10, 1'b1, 1'b0, 4'b0100);
    issue4(4'b1101, 2'b11, 1'b1, 1'b0, 4'b1000);
    issue4(4'b1101, 2'b00, 1'b0, 1'b0, 4'b1101);
    issue4(4'b1101, 2'b01, 1'b0, 1'b0, 4'b0110);
    issue4(4'b1101, 2'b10, 1'b0, 1'b0, 4'b0011);
    issue4(4'b1101, 2'b11, 1'b0, 1'b0, 4'b0001);

    b4.in = 4'b1111; b4.sel = 2'b01; b4.in_valid = 1'b0;
    @(posedge clk); #1;
    check("hold_out", 8'(b4.out), 8'b0001);
    check("hold_valid", 8'(b4.out_valid), 8'h00);
    idle4();

`ifdef BARREL_SHIFTER_ROTATE_EN
    issue4(4'b1101, 2'b01, 1'b1, 1'b1, 4'b1011);
    issue4(4'b1101, 2'b01, 1'b0, 1'b1, 4'b1110);
    issue4(4'b1101, 2'b01, 1'b1, 1'b0, 4'b1010);
    issue4(4'b1101, 2'b01, 1'b0, 1'b0, 4'b0110);
    idle4();
`endif

    for (int i = 0; i < 300; i++) begin
      r = 1'b0;
      b4.in = 4'($urandom); b4.sel = 2'($urandom); b4.sft_lft = 1'($urandom);
      b4.in_valid = ($urandom_range(3, 0) != 0);
      b8.in = 8'($urandom); b8.sel = 3'($urandom); b8.sft_lft = 1'($urandom);
      b8.in_valid = ($urandom_range(3, 0) != 0);
`ifdef BARREL_SHIFTER_ROTATE_EN
      b4.rot = 1'($urandom); b8.rot = 1'($urandom);
      r = b4.rot;
`endif
      if (b4.in_valid) exp4_q.push_back(model4(b4.in, int'(b4.sel), b4.sft_lft, r));
`ifdef BARREL_SHIFTER_ROTATE_EN
      r = b8.rot;
`endif
      if (b8.in_valid) exp8_q.push_back(model8(b8.in, int'(b8.sel), b8.sft_lft, r));
      @(posedge clk); #1;
    end
    b4.in_valid = 1'b0;
    b8.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("drain4", 8'(exp4_q.size()), 8'h00);
    check("drain8", 8'(exp8_q.size()), 8'h00);

    $display("test done: total=%0d bad=%0d", mon_total + dir_total, mon_bad + dir_bad);
    $finish;
  end
endmodule
